// File: rtl/ntt_cmd_dispatch_if.sv
// ---------------------------------------------------------------------------
// ntt_cmd_dispatch_if : host push bus and NTT core issue bus for the dispatcher
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ntt_cmd_dispatch_if;
  logic        host_valid;
  logic        host_ready;
  logic [7:0]  host_opcode;
  logic [3:0]  host_slot;
  logic [47:0] host_addr;

  logic        eng_cmd_valid;
  logic [7:0]  eng_cmd_opcode;
  logic [3:0]  eng_cmd_slot;
  logic [47:0] eng_cmd_dma_addr;
  logic        eng_ready;

  // Dispatcher side
  modport slave (
    input  host_valid, host_opcode, host_slot, host_addr, eng_ready,
    output host_ready, eng_cmd_valid, eng_cmd_opcode, eng_cmd_slot, eng_cmd_dma_addr
  );

  // Environment side (host plus core)
  modport master (
    output host_valid, host_opcode, host_slot, host_addr, eng_ready,
    input  host_ready, eng_cmd_valid, eng_cmd_opcode, eng_cmd_slot, eng_cmd_dma_addr
  );
endinterface

`default_nettype wire

// File: rtl/ntt_cmd_dispatch.sv
// ---------------------------------------------------------------------------
// ntt_cmd_dispatch : command FIFO plus one-at-a-time issue FSM for one NTT core
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ntt_cmd_dispatch #(
  parameter int DEPTH_LOG   = 3,
  parameter int TIMEOUT_CYC = 1048576,
  parameter int CORE_ID     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ntt_cmd_dispatch_if.slave    bus,
  input  logic                 i_flush,
  output logic [DEPTH_LOG:0]   o_fifo_count,
  output logic                 o_idle,
  output logic [31:0]          o_issued_count,
  output logic                 o_timeout_err,
  output logic [1:0]           o_dbg_state
);

  localparam int                 c_DEPTH    = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] c_FULL     = (DEPTH_LOG + 1)'(c_DEPTH);
  localparam int                 c_WD_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_WD_W-1:0]  c_WD_LIMIT = c_WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_LO = 2'd2,
    S_WAIT_HI = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [59:0]            r_mem [0:c_DEPTH-1];
  logic [DEPTH_LOG-1:0]   r_wr_ptr;
  logic [DEPTH_LOG-1:0]   r_rd_ptr;
  logic [DEPTH_LOG:0]     r_count;
  logic [c_WD_W-1:0]      r_wd_cnt;
  logic                   r_cmd_valid;
  logic [7:0]             r_cmd_opcode;
  logic [3:0]             r_cmd_slot;
  logic [47:0]            r_cmd_addr;
  logic [31:0]            r_issued;
  logic                   r_timeout_err;

  logic                   w_host_ready;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_issue;
  logic                   w_wd_clr;
  logic                   w_wd_hit;
  logic                   w_timeout;
  logic [59:0]            w_head;
  logic [7:0]             w_head_op;

  // Ready looks only at the registered count, so a same-cycle pop never opens a full FIFO.
  assign w_host_ready = (r_count < c_FULL);
  assign w_push       = bus.host_valid && w_host_ready && !i_flush;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_op    = w_head[59:52];
  assign w_wd_hit     = (r_wd_cnt == c_WD_LIMIT);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.host_opcode, bus.host_slot, bus.host_addr};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG + 1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A real handshake edge from the core wins over a watchdog expiry in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_wd_clr    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) && !i_flush) begin
          if (w_head_op == 8'h00) begin
            w_pop = 1'b1;
          end else if (bus.eng_ready) begin
            w_pop       = 1'b1;
            w_issue     = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_wd_clr    = 1'b1;
        w_state_nxt = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!bus.eng_ready) begin
          w_wd_clr    = 1'b1;
          w_state_nxt = S_WAIT_HI;
        end else if (w_wd_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_HI: begin
        if (bus.eng_ready) begin
          w_state_nxt = S_IDLE;
        end else if (w_wd_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (w_wd_clr) begin
      r_wd_cnt <= '0;
    end else if ((r_state == S_WAIT_LO) || (r_state == S_WAIT_HI)) begin
      r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_valid   <= 1'b0;
      r_cmd_opcode  <= '0;
      r_cmd_slot    <= '0;
      r_cmd_addr    <= '0;
      r_issued      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_cmd_valid <= w_issue;
      if (w_issue) begin
        r_cmd_opcode <= w_head[59:52];
        r_cmd_slot   <= w_head[51:48];
        r_cmd_addr   <= w_head[47:0];
        r_issued     <= r_issued + 32'd1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign bus.host_ready       = w_host_ready;
  assign bus.eng_cmd_valid    = r_cmd_valid;
  assign bus.eng_cmd_opcode   = r_cmd_opcode;
  assign bus.eng_cmd_slot     = r_cmd_slot;
  assign bus.eng_cmd_dma_addr = r_cmd_addr;

  assign o_fifo_count   = r_count;
  assign o_idle         = (r_count == '0) && (r_state == S_IDLE);
  assign o_issued_count = r_issued;
  assign o_timeout_err  = r_timeout_err;
  assign o_dbg_state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_ntt_cmd_dispatch.sv
// ---------------------------------------------------------------------------
// tb_ntt_cmd_dispatch : directed and random stimulus against a queue-based model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ntt_cmd_dispatch;

  localparam int DL    = 3;
  localparam int DEPTH = 1 << DL;
  localparam int TO    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [DL:0] fifo_count;
  logic        idle;
  logic [31:0] issued_count;
  logic        timeout_err;
  logic [1:0]  dbg_state;

  ntt_cmd_dispatch_if bus();

  ntt_cmd_dispatch #(.DEPTH_LOG(DL), .TIMEOUT_CYC(TO), .CORE_ID(0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .i_flush        (flush),
    .o_fifo_count   (fifo_count),
    .o_idle         (idle),
    .o_issued_count (issued_count),
    .o_timeout_err  (timeout_err),
    .o_dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_strobe = -1;

  // Model: a plain queue of pending commands plus a description of the one in flight.
  logic [59:0] mq[$];
  bit          m_busy, m_strobe, m_low, m_valid, m_terr;
  int          m_wc;
  int unsigned m_issued;
  logic [7:0]  m_op;
  logic [3:0]  m_slot;
  logic [47:0] m_addr;

  bit core_auto = 0, allow_stuck = 0;
  int cphase = 0, cd = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 0; m_strobe = 0; m_low = 0; m_valid = 0; m_terr = 0;
    m_wc = 0; m_issued = 0; m_op = '0; m_slot = '0; m_addr = '0;
    last_strobe = -1;
    cphase = 0; cd = 0;
  endtask

  task automatic model_step();
    bit          do_push;
    logic [59:0] e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    do_push = bus.host_valid && (mq.size() < DEPTH) && !flush;
    m_valid = 0;
    if (!m_busy) begin
      if (mq.size() > 0 && !flush) begin
        e = mq[0];
        if (e[59:52] == 8'h00) begin
          void'(mq.pop_front());
        end else if (bus.eng_ready) begin
          void'(mq.pop_front());
          {m_op, m_slot, m_addr} = e;
          m_valid = 1; m_issued++; m_busy = 1; m_strobe = 1;
        end
      end
    end else if (m_strobe) begin
      m_strobe = 0; m_low = 0; m_wc = 0;
    end else if (!m_low && !bus.eng_ready) begin
      m_low = 1; m_wc = 0;
    end else if (m_low && bus.eng_ready) begin
      m_busy = 0;
    end else if (m_wc == TO - 1) begin
      m_busy = 0; m_terr = 1;
    end else begin
      m_wc++;
    end
    if (flush) mq.delete();
    if (do_push) mq.push_back({bus.host_opcode, bus.host_slot, bus.host_addr});
  endtask

  task automatic check_all();
    int st;
    st = !m_busy ? 0 : m_strobe ? 1 : !m_low ? 2 : 3;
    chk("host_ready",   bus.host_ready,       64'(mq.size() < DEPTH));
    chk("fifo_count",   fifo_count,           64'(mq.size()));
    chk("idle",         idle,                 64'(mq.size() == 0 && !m_busy));
    chk("cmd_valid",    bus.eng_cmd_valid,    64'(m_valid));
    chk("cmd_opcode",   bus.eng_cmd_opcode,   64'(m_op));
    chk("cmd_slot",     bus.eng_cmd_slot,     64'(m_slot));
    chk("cmd_addr",     bus.eng_cmd_dma_addr, 64'(m_addr));
    chk("issued_count", issued_count,         64'(m_issued));
    chk("timeout_err",  timeout_err,          64'(m_terr));
    chk("dbg_state",    dbg_state,            64'(st));
    if (bus.eng_cmd_valid === 1'b1) begin
      if (last_strobe >= 0) chk("strobe_spacing_ge4", 64'(cyc - last_strobe >= 4), 64'd1);
      last_strobe = cyc;
    end
  endtask

  task automatic drive_core();
    if (!core_auto) return;
    case (cphase)
      0: begin
        if (m_valid) begin
          bus.eng_ready = 1'b1;
          if (allow_stuck && $urandom_range(0, 7) == 0) begin
            cphase = 3; cd = 20;
          end else begin
            cphase = 1; cd = $urandom_range(0, 2);
          end
        end else begin
          bus.eng_ready = ($urandom_range(0, 7) != 0);
        end
      end
      1: if (cd == 0) begin bus.eng_ready = 1'b0; cphase = 2; cd = $urandom_range(0, 6); end
         else cd--;
      2: if (cd == 0) begin bus.eng_ready = 1'b1; cphase = 0; end
         else cd--;
      default: begin bus.eng_ready = 1'b1; if (cd == 0) cphase = 0; else cd--; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check_all();
    drive_core();
  endtask

  task automatic set_cmd(input logic [7:0] op, input logic [3:0] sl, input logic [47:0] ad);
    bus.host_valid  = 1'b1;
    bus.host_opcode = op;
    bus.host_slot   = sl;
    bus.host_addr   = ad;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    bus.host_valid = 1'b0;
    while (!(mq.size() == 0 && !m_busy && cphase == 0) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(n < budget), 64'd1);
  endtask

  initial begin
    int          n;
    int          strobes;
    logic [63:0] rnd;
    bus.host_valid = 1'b0; bus.host_opcode = '0; bus.host_slot = '0; bus.host_addr = '0;
    bus.eng_ready  = 1'b1;
    model_reset();
    tick(); tick();
    chk("reset_host_ready", bus.host_ready, 64'd1);
    chk("reset_idle",       idle,           64'd1);
    chk("reset_issued",     issued_count,   64'd0);
    rst_n = 1'b1;
    tick();

    // Single command, core busy for 12 cycles
    set_cmd(8'h0A, 4'd2, 48'h1000);
    tick();
    bus.host_valid = 1'b0;
    tick();
    chk("t1_strobe",  bus.eng_cmd_valid,    64'd1);
    chk("t1_opcode",  bus.eng_cmd_opcode,   64'h0A);
    chk("t1_slot",    bus.eng_cmd_slot,     64'd2);
    chk("t1_addr",    bus.eng_cmd_dma_addr, 64'h1000);
    chk("t1_issued",  issued_count,         64'd1);
    bus.eng_ready = 1'b0;
    tick();
    chk("t1_strobe_one_cycle", bus.eng_cmd_valid, 64'd0);
    repeat (11) tick();
    chk("t1_busy_not_idle", idle, 64'd0);
    bus.eng_ready = 1'b1;
    tick();
    chk("t1_idle_after_ready", idle, 64'd1);

    // Fill the FIFO while the core is held not-ready
    bus.eng_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rnd = {$urandom, $urandom};
      set_cmd(8'($urandom_range(1, 255)), 4'(i), rnd[47:0]);
      tick();
    end
    bus.host_valid = 1'b0;
    chk("t2_full_count", fifo_count,     64'd8);
    chk("t2_full_ready", bus.host_ready, 64'd0);

    // Release the core; the eight drain in order
    core_auto = 1;
    drain("t3_drain_budget", 200);
    chk("t3_issued", issued_count, 64'd9);

    // NOP / ADD / NOP
    set_cmd(8'h00, 4'd1, 48'h1); tick();
    set_cmd(8'h20, 4'd3, 48'h2); tick();
    set_cmd(8'h00, 4'd5, 48'h3); tick();
    drain("t4_drain_budget", 100);
    chk("t4_issued", issued_count, 64'd10);
    chk("t4_opcode", bus.eng_cmd_opcode, 64'h20);
    chk("t4_count",  fifo_count, 64'd0);

    // Flush while the first of three is in the wait-high phase
    core_auto = 0; bus.eng_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_cmd(8'(8'h30 + i), 4'(i), 48'(i));
      tick();
    end
    bus.host_valid = 1'b0;
    n = 0;
    while (!(m_busy && !m_strobe) && n < 10) begin tick(); n++; end
    bus.eng_ready = 1'b0;
    n = 0;
    while (!m_low && n < 10) begin tick(); n++; end
    chk("t5_in_wait_hi", dbg_state, 64'd3);
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (3) tick();
    bus.eng_ready = 1'b1;
    strobes = 0;
    repeat (12) begin tick(); if (bus.eng_cmd_valid === 1'b1) strobes++; end
    chk("t5_no_strobe_after_flush", 64'(strobes), 64'd0);
    chk("t5_count",  fifo_count,   64'd0);
    chk("t5_issued", issued_count, 64'd11);

    // Core never acknowledges: watchdog expiry
    chk("t6_err_before", timeout_err, 64'd0);
    set_cmd(8'h41, 4'd7, 48'hABC); tick();
    set_cmd(8'h42, 4'd8, 48'hDEF); tick();
    bus.host_valid = 1'b0;
    chk("t6_first_strobe", bus.eng_cmd_valid, 64'd1);
    repeat (16) tick();
    chk("t6_err_not_yet", timeout_err, 64'd0);
    tick();
    chk("t6_err_set",   timeout_err, 64'd1);
    chk("t6_state_idle", dbg_state,  64'd0);
    tick();
    chk("t6_next_strobe", bus.eng_cmd_valid,  64'd1);
    chk("t6_next_opcode", bus.eng_cmd_opcode, 64'h42);
    chk("t6_issued",      issued_count,       64'd13);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid",   bus.eng_cmd_valid,  64'd0);
    chk("t6_rst_opcode",  bus.eng_cmd_opcode, 64'd0);
    chk("t6_rst_issued",  issued_count,       64'd0);
    chk("t6_rst_err",     timeout_err,        64'd0);
    chk("t6_rst_idle",    idle,               64'd1);
    chk("t6_rst_state",   dbg_state,          64'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();

    // Random traffic with NOPs, flushes, stalls and the odd stuck core
    core_auto = 1; allow_stuck = 1;
    repeat (2000) begin
      rnd = {$urandom, $urandom};
      bus.host_valid  = ($urandom_range(0, 3) != 0);
      bus.host_opcode = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      bus.host_slot   = 4'($urandom_range(0, 15));
      bus.host_addr   = rnd[47:0];
      flush           = ($urandom_range(0, 60) == 0);
      tick();
    end
    flush = 1'b0; allow_stuck = 0;
    drain("rand_drain_budget", 400);
    chk("rand_final_idle", idle, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
